// File: rtl/lsu_ctrl_if.sv
// Request, response and data-memory signal bundle for the load/store controller.
// slave = controller side, master = pipeline/memory environment side.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_exc;
    logic [31:0] resp_pc;

    logic        mem_we;
    logic [31:0] mem_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_select;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc,
        input  resp_ready, mem_rdata,
        output req_ready,
        output resp_valid, resp_data, resp_exc, resp_pc,
        output mem_we, mem_pc, mem_addr, mem_wdata, mem_byte_select
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc,
        output resp_ready, mem_rdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_exc, resp_pc,
        input  mem_we, mem_pc, mem_addr, mem_wdata, mem_byte_select
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request in flight, drives DM for one ACCESS cycle, returns registered response.
// Latency: response valid 2 cycles after accept (1 on misaligned/out-of-range); no DM access on exceptions.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready, store already committed.
module lsu_ctrl #(
    parameter int unsigned RAM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    lsu_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [32:0] ADDR_LIMIT = 33'(RAM_WORDS) * 33'd4;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [1:0]  resp_exc_q, resp_exc_d;
    logic [31:0] resp_pc_q, resp_pc_d;

    logic        misaligned;
    logic        out_of_range;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        state_d     = state_q;
        armed_d     = 1'b1;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        resp_data_d = resp_data_q;
        resp_exc_d  = resp_exc_q;
        resp_pc_d   = resp_pc_q;

        bus.req_ready       = 1'b0;
        bus.resp_valid      = 1'b0;
        bus.mem_we          = 1'b0;
        bus.mem_pc          = 32'd0;
        bus.mem_addr        = 32'd0;
        bus.mem_wdata       = 32'd0;
        bus.mem_byte_select = 4'd0;

        misaligned = 1'b0;
        case (bus.req_op)
            OP_LW, OP_SW:          misaligned = |bus.req_addr[1:0];
            OP_LH, OP_LHU, OP_SH:  misaligned = bus.req_addr[0];
            default:               misaligned = 1'b0;
        endcase
        out_of_range = ({1'b0, bus.req_addr} >= ADDR_LIMIT);

        ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        case (state_q)
            S_IDLE: begin
                // armed_q keeps the block closed until the first edge after reset release
                bus.req_ready = armed_q;
                if (armed_q && bus.req_valid) begin
                    op_d        = bus.req_op;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    pc_d        = bus.req_pc;
                    resp_pc_d   = bus.req_pc;
                    resp_data_d = 32'd0;
                    if (misaligned) begin
                        resp_exc_d = 2'b01;
                        state_d    = S_RESP;
                    end else if (out_of_range) begin
                        resp_exc_d = 2'b10;
                        state_d    = S_RESP;
                    end else begin
                        resp_exc_d = 2'b00;
                        state_d    = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                bus.mem_addr = addr_q;
                bus.mem_pc   = pc_q;
                resp_exc_d   = 2'b00;
                state_d      = S_RESP;
                if (op_q >= OP_SW) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = wdata_q;
                    resp_data_d   = 32'd0;
                    case (op_q)
                        OP_SB:   bus.mem_byte_select = 4'b0001 << addr_q[1:0];
                        OP_SH:   bus.mem_byte_select = addr_q[1] ? 4'b1100 : 4'b0011;
                        default: bus.mem_byte_select = 4'b1111;
                    endcase
                end else begin
                    case (op_q)
                        OP_LH:   resp_data_d = {{16{ld_half[15]}}, ld_half};
                        OP_LHU:  resp_data_d = {16'd0, ld_half};
                        OP_LB:   resp_data_d = {{24{ld_byte[7]}}, ld_byte};
                        OP_LBU:  resp_data_d = {24'd0, ld_byte};
                        default: resp_data_d = bus.mem_rdata;
                    endcase
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.resp_data = resp_data_q;
    assign bus.resp_exc  = resp_exc_q;
    assign bus.resp_pc   = resp_pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            op_q        <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            pc_q        <= 32'd0;
            resp_data_q <= 32'd0;
            resp_exc_q  <= 2'd0;
            resp_pc_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            resp_data_q <= resp_data_d;
            resp_exc_q  <= resp_exc_d;
            resp_pc_q   <= resp_pc_d;
        end
    end
endmodule
